// File: rtl/cronometru_pkg.sv
// Shared encodings for the stopwatch control block: FSM state codes and width.
package cronometru_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  // Counters advance both while running and while a lap is frozen on display.
  function automatic logic state_counts(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/debounce_buton.sv
// Button input conditioning: 2-FF synchroniser, tick-sampled debounce, press pulse.
module debounce_buton #(
  parameter int DEB_TICKS = 16
) (
  input  logic clk_in,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // The level flips on the DEB_TICKS-th consecutive disagreeing tick sample;
  // press is registered alongside so it lines up with the new level.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      press  <= 1'b0;
      if (tick) begin
        if (sync_q[1] == level) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
          cnt_q <= '0;
          level <= sync_q[1];
          press <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/control_cronometru.sv
// Stopwatch control FSM: debounced start/stop and lap/reset buttons drive counter
// enable/clear, lap capture and display select. Optional: LONG_PRESS_CLR_EN.
module control_cronometru
  import cronometru_pkg::*;
#(
  parameter int DEB_TICKS  = 16,
  parameter int LONG_TICKS = 2000
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick,
  input  logic               btn_ss,
  input  logic               btn_lr,
  output logic               count_en,
  output logic               count_clr,
  output logic               lap_latch,
  output logic               disp_sel,
  output logic [STATE_W-1:0] state
);

  logic   ss_lvl, ss_p;
  logic   lr_lvl, lr_p;
  logic   long_hit;
  state_t st_q, st_d;
  logic   clr_d, lat_d;

  debounce_buton #(.DEB_TICKS(DEB_TICKS)) u_deb_ss (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (tick),
    .btn_raw(btn_ss),
    .level  (ss_lvl),
    .press  (ss_p)
  );

  debounce_buton #(.DEB_TICKS(DEB_TICKS)) u_deb_lr (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (tick),
    .btn_raw(btn_lr),
    .level  (lr_lvl),
    .press  (lr_p)
  );

  logic ss_lvl_unused;
  assign ss_lvl_unused = ss_lvl;

`ifdef LONG_PRESS_CLR_EN
  localparam int LW = $clog2(LONG_TICKS + 1);

  logic [LW-1:0] lp_cnt_q;

  // Saturates at LONG_TICKS so a single hold yields exactly one forced clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lp_cnt_q <= '0;
    end else if (!lr_lvl) begin
      lp_cnt_q <= '0;
    end else if (tick && (lp_cnt_q != LW'(LONG_TICKS))) begin
      lp_cnt_q <= lp_cnt_q + LW'(1);
    end
  end

  assign long_hit = tick && lr_lvl && (lp_cnt_q == LW'(LONG_TICKS - 1));
`else
  localparam int LONG_TICKS_UNUSED = LONG_TICKS;
  logic lr_lvl_unused;
  assign lr_lvl_unused = lr_lvl;
  assign long_hit      = 1'b0;
`endif

  // ss_p has priority over a coincident lr_p, which is simply dropped.
  always_comb begin
    st_d  = st_q;
    clr_d = 1'b0;
    lat_d = 1'b0;
    if (long_hit) begin
      st_d  = ST_IDLE;
      clr_d = 1'b1;
    end else if (ss_p) begin
      case (st_q)
        ST_IDLE: st_d = ST_RUN;
        ST_RUN:  st_d = ST_STOP;
        ST_LAP:  st_d = ST_STOP;
        ST_STOP: st_d = ST_RUN;
        default: st_d = ST_IDLE;
      endcase
    end else if (lr_p) begin
      case (st_q)
        ST_IDLE: begin
          st_d  = ST_IDLE;
          clr_d = 1'b1;
        end
        ST_RUN: begin
          st_d  = ST_LAP;
          lat_d = 1'b1;
        end
        ST_LAP:  st_d = ST_RUN;
        ST_STOP: begin
          st_d  = ST_IDLE;
          clr_d = 1'b1;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      st_q      <= ST_IDLE;
      count_en  <= 1'b0;
      disp_sel  <= 1'b0;
      count_clr <= 1'b0;
      lap_latch <= 1'b0;
    end else begin
      st_q      <= st_d;
      count_en  <= state_counts(st_d);
      disp_sel  <= (st_d == ST_LAP);
      count_clr <= clr_d;
      lap_latch <= lat_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_control_cronometru.sv
// Bench for control_cronometru: rule-level model checked every cycle plus directed scenarios.
module tb_control_cronometru;

  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       tick   = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       count_en, count_clr, lap_latch, disp_sel;
  logic [1:0] state;

  control_cronometru #(.DEB_TICKS(DEB), .LONG_TICKS(LONG)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tick     (tick),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .count_en (count_en),
    .count_clr(count_clr),
    .lap_latch(lap_latch),
    .disp_sel (disp_sel),
    .state    (state)
  );

  initial forever #5 clk_in = ~clk_in;
  initial forever begin
    @(negedge clk_in);
    tick = ~tick;
  end

  // ---------------- behavioural model ----------------
  // Button sample seen by the debouncer is the raw level from two clocks ago.
  // A level flips after DEB consecutive tick samples disagreeing with it;
  // a rising flip is a press, acted on by the state table one clock later.
  localparam logic [1:0] NXT_SS [4] = '{2'b01, 2'b11, 2'b11, 2'b01};
  localparam logic [1:0] NXT_LR [4] = '{2'b00, 2'b10, 2'b01, 2'b00};

  logic [1:0] m_dly [2];
  int         m_run [2];
  logic       m_lvl [2];
  logic       m_p   [2];
  logic [1:0] m_st;
  logic       m_clr, m_lat;
  int         m_lp;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        m_dly[b] <= 2'b00;
        m_run[b] <= 0;
        m_lvl[b] <= 1'b0;
        m_p[b]   <= 1'b0;
      end
      m_st  <= 2'b00;
      m_clr <= 1'b0;
      m_lat <= 1'b0;
      m_lp  <= 0;
    end else begin
      logic hit;
      for (int b = 0; b < 2; b++) begin
        m_dly[b] <= {m_dly[b][0], (b == 0) ? btn_ss : btn_lr};
        m_p[b]   <= 1'b0;
        if (tick) begin
          if (m_dly[b][1] == m_lvl[b]) m_run[b] <= 0;
          else if (m_run[b] + 1 >= DEB) begin
            m_run[b] <= 0;
            m_lvl[b] <= m_dly[b][1];
            m_p[b]   <= m_dly[b][1];
          end else m_run[b] <= m_run[b] + 1;
        end
      end
      hit = 1'b0;
`ifdef LONG_PRESS_CLR_EN
      if (!m_lvl[1]) m_lp <= 0;
      else if (tick && m_lp < LONG) m_lp <= m_lp + 1;
      hit = tick && m_lvl[1] && (m_lp == LONG - 1);
`endif
      m_clr <= 1'b0;
      m_lat <= 1'b0;
      if (hit) begin
        m_st  <= 2'b00;
        m_clr <= 1'b1;
      end else if (m_p[0]) begin
        m_st <= NXT_SS[m_st];
      end else if (m_p[1]) begin
        m_st  <= NXT_LR[m_st];
        m_clr <= (m_st == 2'b00) || (m_st == 2'b11);
        m_lat <= (m_st == 2'b01);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_vec_c = 0, n_err_c = 0;
  int n_vec_h = 0, n_err_h = 0;
  int n_clr = 0, n_lat = 0;

  task automatic chk_c(input string nm, input int act, input int exp);
    n_vec_c++;
    if (act != exp) begin
      n_err_c++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_h(input string nm, input int act, input int exp);
    n_vec_h++;
    if (act != exp) begin
      n_err_h++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    chk_c("state", state, m_st);
    chk_c("count_en", count_en, (m_st == 2'b01) || (m_st == 2'b10));
    chk_c("disp_sel", disp_sel, m_st == 2'b10);
    chk_c("count_clr", count_clr, m_clr);
    chk_c("lap_latch", lap_latch, m_lat);
    chk_c("clr_lat_excl", count_clr & lap_latch, 0);
    if (count_clr) n_clr++;
    if (lap_latch) n_lat++;
  end

  // ---------------- directed scenarios ----------------
  task automatic hold(input logic s, input logic l, input int ticks);
    btn_ss = s;
    btn_lr = l;
    repeat (2 * ticks) @(negedge clk_in);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (16) @(negedge clk_in);
  endtask

  initial begin
    int cyc, clr0, lat0;
    @(negedge clk_in);
    chk_h("reset_state", state, 0);
    chk_h("reset_outs", {count_en, count_clr, lap_latch, disp_sel}, 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);

    // 1: start press latency and no repeat while held
    btn_ss = 1'b1;
    cyc = 0;
    while (!count_en && cyc < 30) begin
      @(negedge clk_in);
      cyc++;
    end
    chk_h("ss_latency_9_to_12", (cyc >= 9 && cyc <= 12) ? 1 : 0, 1);
    repeat (12 - cyc) @(negedge clk_in);
    btn_ss = 1'b0;
    repeat (16) @(negedge clk_in);
    chk_h("t1_state_run", state, 1);
    chk_h("t1_model_run", m_st, 2'b01);

    // 2: short lr glitch ignored, clean lr enters LAP with one latch pulse
    lat0 = n_lat;
    hold(1'b0, 1'b1, 3);
    chk_h("t2_glitch_state", state, 1);
    chk_h("t2_glitch_latch", n_lat - lat0, 0);
    hold(1'b0, 1'b1, 6);
    chk_h("t2_latch_once", n_lat - lat0, 1);
    chk_h("t2_state_lap", state, 2);
    chk_h("t2_disp_sel", disp_sel, 1);
    chk_h("t2_count_en", count_en, 1);

    // back to IDLE: LAP -lr-> RUN -ss-> STOP -lr-> IDLE
    hold(1'b0, 1'b1, 6);
    chk_h("lap_to_run", state, 1);
    hold(1'b1, 1'b0, 6);
    hold(1'b0, 1'b1, 6);
    chk_h("back_idle", state, 0);

    // 3: ss, ss, lr from IDLE
    clr0 = n_clr;
    hold(1'b1, 1'b0, 6);
    chk_h("t3_run", state, 1);
    hold(1'b1, 1'b0, 6);
    chk_h("t3_stop", state, 3);
    chk_h("t3_no_clr_yet", n_clr - clr0, 0);
    hold(1'b0, 1'b1, 6);
    chk_h("t3_idle", state, 0);
    chk_h("t3_clr_once", n_clr - clr0, 1);

    // 4: both buttons together in RUN -> STOP, no latch
    hold(1'b1, 1'b0, 6);
    lat0 = n_lat;
    hold(1'b1, 1'b1, 6);
    chk_h("t4_stop", state, 3);
    chk_h("t4_model_stop", m_st, 2'b11);
    chk_h("t4_no_latch", n_lat - lat0, 0);
    hold(1'b0, 1'b1, 6);

    // 5: reset in LAP with lr held, then held button clears after release
    hold(1'b1, 1'b0, 6);
    btn_lr = 1'b1;
    repeat (14) @(negedge clk_in);
    chk_h("t5_lap", state, 2);
    reset = 1'b0;
    #1;
    chk_h("t5_async_state", state, 0);
    chk_h("t5_async_outs", {count_en, count_clr, lap_latch, disp_sel}, 0);
    repeat (3) @(negedge clk_in);
    clr0 = n_clr;
    reset = 1'b1;
    repeat (16) @(negedge clk_in);
    chk_h("t5_idle", state, 0);
    chk_h("t5_clr_once", n_clr - clr0, 1);
    btn_lr = 1'b0;
    repeat (16) @(negedge clk_in);

    // 6: long lr hold from RUN
    hold(1'b1, 1'b0, 6);
    clr0 = n_clr;
    hold(1'b0, 1'b1, 15);
`ifdef LONG_PRESS_CLR_EN
    chk_h("t6_long_idle", state, 0);
    chk_h("t6_long_clr", n_clr - clr0, 1);
`else
    chk_h("t6_stays_lap", state, 2);
    chk_h("t6_no_clr", n_clr - clr0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec_c + n_vec_h, n_err_c + n_err_h);
    $finish;
  end

endmodule

// File: doc/control_cronometru.md
Name: control_cronometru

Overview:
Stopwatch control FSM that sequences the two cascaded counters and the 7-segment display path. Two raw push-buttons come in and are synchronised and debounced on a tick enable. The block then drives the counter run-enable, a synchronous clear, a lap-capture strobe and the live/lap display select. Sits between the board buttons and the counter/bin2bcd/afisare_7seg chain, clocked by clk_in.

Parameters:
DEB_TICKS, 16, consecutive stable tick samples required to accept a button level change (>=2)
LONG_TICKS, 2000, tick samples of continuous lr hold for long-press clear (used only with LONG_PRESS_CLR_EN)

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tick  input  1  one-cycle sampling enable, nominally 1 kHz, from the clock divider
btn_ss  input  1  start/stop button, raw, active-high, asynchronous to clk_in
btn_lr  input  1  lap/reset button, raw, active-high, asynchronous to clk_in
count_en  output  1  counters advance while 1
count_clr  output  1  one-cycle synchronous clear to counters
lap_latch  output  1  one-cycle strobe: capture live count into the lap register
disp_sel  output  1  0 = display live count, 1 = display lap register
state  output  2  current FSM state, for debug LEDs

Behaviour:
- Reset (reset=0, async): state=IDLE; count_en, count_clr, lap_latch, disp_sel = 0; sync flops, debounce counters and debounced levels = 0 (released).
- Input path, per button: 2-FF synchroniser, then debounce.
  - On each tick, compare the synced sample with the debounced level. If they differ, increment the counter; if equal, clear it to 0.
  - When the counter reaches DEB_TICKS, set the debounced level to the sample and clear the counter.
  - A 0->1 change of the debounced level gives a one-cycle press pulse (ss_p, lr_p). Release produces no pulse.
  - Counter width is $clog2(DEB_TICKS+1).
- Latency: stable press to press pulse = 2 sync cycles + DEB_TICKS ticks + 1 cycle. FSM outputs update on the clock edge after the pulse.
- Glitch shorter than DEB_TICKS ticks: no pulse, no state change.
- States: IDLE=2'b00, RUN=2'b01, LAP=2'b10, STOP=2'b11.
  - IDLE: ss_p -> RUN. lr_p -> stay IDLE, pulse count_clr.
  - RUN: ss_p -> STOP. lr_p -> LAP, pulse lap_latch.
  - LAP: ss_p -> STOP. lr_p -> RUN (display returns to live).
  - STOP: ss_p -> RUN. lr_p -> IDLE, pulse count_clr.
- Simultaneous ss_p and lr_p in the same cycle: ss_p wins and lr_p is discarded.
- Output decode:
  - count_en = (state==RUN || state==LAP), registered with state.
  - disp_sel = (state==LAP).
  - count_clr and lap_latch are registered, exactly one cycle, never asserted together.
- tick held high continuously is legal: sampling then happens every clock.
- Reset asserted mid-press: all state discarded. A button still held at reset release produces a press pulse after debounce, because the debounced level restarts at 0.

Optional Feature:
LONG_PRESS_CLR_EN
- Defined: a second counter counts ticks while the lr debounced level is 1 and clears on release.
  - Reaching LONG_TICKS in any state forces state=IDLE with a one-cycle count_clr.
  - The counter then saturates until release, so there is only one clear per hold.
  - The short-press lr_p from the same hold has already acted at press time; that is intended.
- Undefined: no long-press counter; LONG_TICKS is unused; behaviour is exactly as above.

Decomposition:
- Package cronometru_pkg: state encodings (ST_IDLE, ST_RUN, ST_LAP, ST_STOP) and the 2-bit state width constant.
- Sub-module debounce_buton (clk_in, reset, tick, btn_raw -> level, press): synchroniser, debounce counter and edge pulse. Parameterised by DEB_TICKS, instantiated twice.
- FSM and optional long-press logic live in control_cronometru.

Test Plan:
1. DEB_TICKS=4, tick every 2 clocks; hold btn_ss high for 6 ticks from IDLE -> one ss_p, state=RUN, count_en=1 about 11 clocks after press, no second transition while held.
2. In RUN, 3-tick glitch on btn_lr -> no lap_latch, state stays RUN; then a clean lr press -> lap_latch high exactly 1 cycle, state=LAP, disp_sel=1, count_en stays 1.
3. Sequence from IDLE: ss, ss, lr -> states RUN, STOP, IDLE; count_clr pulses once, on STOP->IDLE only.
4. Both buttons pressed in the same clock while in RUN -> state=STOP, lap_latch never asserted.
5. Assert reset=0 for 3 clocks while in LAP with btn_lr held -> state=IDLE and all outputs 0 immediately (async); after release, one lr_p after DEB_TICKS ticks gives count_clr, state stays IDLE.
6. With LONG_PRESS_CLR_EN, LONG_TICKS=10: from RUN hold lr for 15 ticks -> LAP at press time, then IDLE with a single count_clr at tick 10 of the hold; without the macro -> stays LAP.
